// File: rtl/control_pipe_unit_if.sv
// -----------------------------------------------------------------------------
// control_pipe_unit_if
// Bundles the IF/ID-side inputs and the ID/EX control-latch outputs of
// control_pipe_unit.
//   master : fetch/pipeline controller side (drives imemload, id_valid,
//            ex_stall and flush; observes the hazard stall and the control bundle)
//   slave  : control_pipe_unit side
// Signals:
//   imemload[31:0]   instruction held in IF/ID
//   id_valid         imemload holds a valid fetched instruction
//   ex_stall         downstream freeze
//   flush            branch/jump taken, squash ID
//   hazard_stall     load-use stall request (combinational)
//   ex_*             registered control bundle and register specifiers
//   halt_out         sticky system halt
// -----------------------------------------------------------------------------
interface control_pipe_unit_if #(
  parameter int ALUOP_W = 4
);
  logic [31:0]        imemload;
  logic               id_valid;
  logic               ex_stall;
  logic               flush;
  logic               hazard_stall;
  logic [1:0]         ex_ALUsrc;
  logic [1:0]         ex_memtoreg;
  logic               ex_signzero;
  logic [ALUOP_W-1:0] ex_ALUop;
  logic               ex_regwrite;
  logic [1:0]         ex_pcselect;
  logic [1:0]         ex_regdst;
  logic               ex_branch;
  logic               ex_dmemREN;
  logic               ex_dmemWEN;
  logic [4:0]         ex_rs;
  logic [4:0]         ex_rt;
  logic [4:0]         ex_rd;
  logic               ex_halt;
  logic               halt_out;

  modport master (
    output imemload, id_valid, ex_stall, flush,
    input  hazard_stall, ex_ALUsrc, ex_memtoreg, ex_signzero, ex_ALUop,
           ex_regwrite, ex_pcselect, ex_regdst, ex_branch, ex_dmemREN,
           ex_dmemWEN, ex_rs, ex_rt, ex_rd, ex_halt, halt_out
  );

  modport slave (
    input  imemload, id_valid, ex_stall, flush,
    output hazard_stall, ex_ALUsrc, ex_memtoreg, ex_signzero, ex_ALUop,
           ex_regwrite, ex_pcselect, ex_regdst, ex_branch, ex_dmemREN,
           ex_dmemWEN, ex_rs, ex_rt, ex_rd, ex_halt, halt_out
  );
endinterface

// File: rtl/control_pipe_unit.sv
// -----------------------------------------------------------------------------
// control_pipe_unit
// Decodes the IF/ID instruction into the control bundle and registers it,
// together with rs/rt/rd, into the ID/EX control latch. Detects load-use
// hazards, honours downstream stall and branch flush, and raises a sticky halt
// once a HALT has sat in ID/EX and DRAIN non-stalled cycles have elapsed.
// Ports:
//   CLK   : system clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : control_pipe_unit_if.slave (instruction in, control bundle out)
// -----------------------------------------------------------------------------
module control_pipe_unit #(
  parameter int ALUOP_W   = 4,
  parameter int DRAIN     = 3,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic                CLK,
  input logic                nRST,
  control_pipe_unit_if.slave bus
);

  typedef struct packed {
    logic [1:0]         alusrc;
    logic [1:0]         memtoreg;
    logic               signzero;
    logic [ALUOP_W-1:0] aluop;
    logic               regwrite;
    logic [1:0]         pcselect;
    logic [1:0]         regdst;
    logic               branch;
    logic               dren;
    logic               dwen;
    logic               halt;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09,
                         OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B, OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR  = 6'h08,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
                         FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR = 6'h27,
                         FN_SLT  = 6'h2A, FN_SLTU = 6'h2B, FN_HALT = 6'h3F;

  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(0), ALU_SRL  = ALUOP_W'(1),
                                 ALU_AND  = ALUOP_W'(2), ALU_OR   = ALUOP_W'(3),
                                 ALU_XOR  = ALUOP_W'(4), ALU_NOR  = ALUOP_W'(5),
                                 ALU_ADDU = ALUOP_W'(6), ALU_SUBU = ALUOP_W'(7),
                                 ALU_SLT  = ALUOP_W'(8), ALU_SLTU = ALUOP_W'(9);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN);

  ctrl_t      r_ctrl;
  logic [4:0] r_rs, r_rt, r_rd;
  logic       r_halt_pending;
  logic [3:0] r_drain_cnt;
  logic       r_halt_out;

  ctrl_t      w_dec;
  logic [5:0] w_op, w_funct;
  logic [4:0] w_rs, w_rt, w_rd;
  logic       w_uses_rt;
  logic       w_hazard;
  logic       w_bubble;
  logic       w_unused;

  assign w_op     = bus.imemload[31:26];
  assign w_rs     = bus.imemload[25:21];
  assign w_rt     = bus.imemload[20:16];
  assign w_rd     = bus.imemload[15:11];
  assign w_funct  = bus.imemload[5:0];
  // Shamt is consumed by the execute stage straight from the instruction.
  assign w_unused = ^bus.imemload[10:6];

  always_comb begin
    // NOTE: defaulting every field first keeps this block free of latches.
    w_dec = '0;
    case (w_op)
      OP_RTYPE: begin
        if (bus.imemload != 32'h0) begin
          w_dec.regwrite = 1'b1;
          w_dec.regdst   = 2'd1;
          case (w_funct)
            FN_ADDU: w_dec.aluop = ALU_ADDU;
            FN_SUBU: w_dec.aluop = ALU_SUBU;
            FN_AND:  w_dec.aluop = ALU_AND;
            FN_OR:   w_dec.aluop = ALU_OR;
            FN_XOR:  w_dec.aluop = ALU_XOR;
            FN_NOR:  w_dec.aluop = ALU_NOR;
            FN_SLT:  w_dec.aluop = ALU_SLT;
            FN_SLTU: w_dec.aluop = ALU_SLTU;
            FN_SLL:  begin w_dec.alusrc = 2'd2; w_dec.aluop = ALU_SLL; end
            FN_SRL:  begin w_dec.alusrc = 2'd2; w_dec.aluop = ALU_SRL; end
            FN_JR:   begin w_dec.pcselect = 2'd1; w_dec.regwrite = 1'b0; end
            default: w_dec = '0;
          endcase
        end
      end
      OP_ADDIU: begin w_dec.alusrc = 2'd1; w_dec.regwrite = 1'b1; w_dec.signzero = 1'b1; w_dec.aluop = ALU_ADDU; end
      OP_ANDI:  begin w_dec.alusrc = 2'd1; w_dec.regwrite = 1'b1; w_dec.aluop = ALU_AND; end
      OP_ORI:   begin w_dec.alusrc = 2'd1; w_dec.regwrite = 1'b1; w_dec.aluop = ALU_OR; end
      OP_XORI:  begin w_dec.alusrc = 2'd1; w_dec.regwrite = 1'b1; w_dec.aluop = ALU_XOR; end
      OP_SLTI:  begin w_dec.alusrc = 2'd1; w_dec.regwrite = 1'b1; w_dec.signzero = 1'b1; w_dec.aluop = ALU_SLT; end
      OP_SLTIU: begin w_dec.alusrc = 2'd1; w_dec.regwrite = 1'b1; w_dec.signzero = 1'b1; w_dec.aluop = ALU_SLTU; end
      OP_LW: begin
        w_dec.alusrc   = 2'd1;
        w_dec.dren     = 1'b1;
        w_dec.memtoreg = 2'd1;
        w_dec.signzero = 1'b1;
        w_dec.aluop    = ALU_ADDU;
        w_dec.regwrite = 1'b1;
      end
      OP_SW: begin
        w_dec.alusrc   = 2'd1;
        w_dec.dwen     = 1'b1;
        w_dec.signzero = 1'b1;
        w_dec.aluop    = ALU_ADDU;
      end
      OP_BEQ, OP_BNE: begin
        w_dec.aluop    = ALU_SUBU;
        w_dec.signzero = 1'b1;
        w_dec.pcselect = 2'd2;
        w_dec.branch   = (w_op == OP_BEQ);
      end
      OP_LUI: begin w_dec.alusrc = 2'd1; w_dec.memtoreg = 2'd2; w_dec.regwrite = 1'b1; end
      OP_J:   begin w_dec.alusrc = 2'd1; w_dec.pcselect = 2'd3; end
      OP_JAL: begin
        w_dec.alusrc   = 2'd1;
        w_dec.pcselect = 2'd3;
        w_dec.memtoreg = 2'd3;
        w_dec.regdst   = 2'd2;
        w_dec.regwrite = 1'b1;
      end
      OP_HALT: w_dec.halt = (w_funct == FN_HALT);
      default: w_dec = '0;
    endcase
  end

  // rs is compared for every instruction; rt only where it is a source.
  assign w_uses_rt = (w_op == OP_RTYPE) || (w_op == OP_BEQ) ||
                     (w_op == OP_BNE)   || (w_op == OP_SW);

  assign w_hazard = HAZARD_EN && bus.id_valid && !r_halt_pending &&
                    r_ctrl.dren && (r_rt != 5'd0) &&
                    ((w_rs == r_rt) || (w_uses_rt && (w_rt == r_rt)));

  assign w_bubble = bus.flush || w_hazard || !bus.id_valid || r_halt_pending;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ctrl         <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_rd           <= '0;
      r_halt_pending <= 1'b0;
      r_drain_cnt    <= '0;
      r_halt_out     <= 1'b0;
    end else if (!bus.ex_stall) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (w_bubble) begin
        r_ctrl <= '0;
        r_rs   <= '0;
        r_rt   <= '0;
        r_rd   <= '0;
      end else begin
        r_ctrl <= w_dec;
        r_rs   <= w_rs;
        r_rt   <= w_rt;
        r_rd   <= w_rd;
        if (w_dec.halt) begin
          r_halt_pending <= 1'b1;
          r_drain_cnt    <= DRAIN_INIT;
        end
      end
      // Once pending, halt is never cancelled by later flushes.
      if (r_halt_pending) begin
        if (r_drain_cnt != 4'd0) r_drain_cnt <= r_drain_cnt - 4'd1;
        else                     r_halt_out  <= 1'b1;
      end
    end
  end

  assign bus.hazard_stall = w_hazard;
  assign bus.ex_ALUsrc    = r_ctrl.alusrc;
  assign bus.ex_memtoreg  = r_ctrl.memtoreg;
  assign bus.ex_signzero  = r_ctrl.signzero;
  assign bus.ex_ALUop     = r_ctrl.aluop;
  assign bus.ex_regwrite  = r_ctrl.regwrite;
  assign bus.ex_pcselect  = r_ctrl.pcselect;
  assign bus.ex_regdst    = r_ctrl.regdst;
  assign bus.ex_branch    = r_ctrl.branch;
  assign bus.ex_dmemREN   = r_ctrl.dren;
  assign bus.ex_dmemWEN   = r_ctrl.dwen;
  assign bus.ex_halt      = r_ctrl.halt;
  assign bus.ex_rs        = r_rs;
  assign bus.ex_rt        = r_rt;
  assign bus.ex_rd        = r_rd;
  assign bus.halt_out     = r_halt_out;

endmodule

// File: tb/tb_control_pipe_unit.sv
module tb_control_pipe_unit;

  typedef logic [17:0] cvec_t;

  localparam logic [31:0] I_ADDU   = 32'h00221821;  // addu $3,$1,$2
  localparam logic [31:0] I_ADDU3  = 32'h00611021;  // addu $2,$3,$1
  localparam logic [31:0] I_LW     = 32'h8C430004;  // lw   $3,4($2)
  localparam logic [31:0] I_LW0    = 32'h8C400004;  // lw   $0,4($2)
  localparam logic [31:0] I_ADDU00 = 32'h00001021;  // addu $2,$0,$0
  localparam logic [31:0] I_BEQ    = 32'h10230000;  // beq  $1,$3
  localparam logic [31:0] I_ADDIU  = 32'h24A30001;  // addiu $3,$5,1
  localparam logic [31:0] I_HALT   = 32'hFC00003F;

  logic CLK = 1'b0;
  logic nRST;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 CLK = ~CLK;

  control_pipe_unit_if #(.ALUOP_W(4)) bus ();
  control_pipe_unit_if #(.ALUOP_W(4)) nh ();

  control_pipe_unit #(.ALUOP_W(4), .DRAIN(3), .HAZARD_EN(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );
  control_pipe_unit #(.ALUOP_W(4), .DRAIN(3), .HAZARD_EN(1'b0)) dut_nh (
    .CLK(CLK), .nRST(nRST), .bus(nh)
  );

  // {ALUsrc, memtoreg, signzero, ALUop, regwrite, pcselect, regdst, branch, REN, WEN, halt}
  function automatic cvec_t mk(int alusrc, int m2r, int sz, int aluop, int rw,
                               int pc, int rdst, int br, int ren, int wen, int h);
    return {2'(alusrc), 2'(m2r), 1'(sz), 4'(aluop), 1'(rw), 2'(pc), 2'(rdst),
            1'(br), 1'(ren), 1'(wen), 1'(h)};
  endfunction

  function automatic cvec_t got(bit sel);
    if (sel)
      return {nh.ex_ALUsrc, nh.ex_memtoreg, nh.ex_signzero, nh.ex_ALUop, nh.ex_regwrite,
              nh.ex_pcselect, nh.ex_regdst, nh.ex_branch, nh.ex_dmemREN, nh.ex_dmemWEN,
              nh.ex_halt};
    return {bus.ex_ALUsrc, bus.ex_memtoreg, bus.ex_signzero, bus.ex_ALUop, bus.ex_regwrite,
            bus.ex_pcselect, bus.ex_regdst, bus.ex_branch, bus.ex_dmemREN, bus.ex_dmemWEN,
            bus.ex_halt};
  endfunction

  task automatic drive(logic [31:0] instr, logic valid, logic stall, logic fl);
    bus.imemload = instr; bus.id_valid = valid; bus.ex_stall = stall; bus.flush = fl;
    nh.imemload  = instr; nh.id_valid  = valid; nh.ex_stall  = stall; nh.flush  = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    #12;
    n_checks++;
    if (got(0) !== 18'h0) begin
      n_errors++; $display("FAIL reset_ctrl got=%h exp=%h", got(0), 18'h0);
    end
    n_checks++;
    if ({bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.halt_out, bus.hazard_stall} !== 17'h0) begin
      n_errors++;
      $display("FAIL reset_regs got=%h exp=0", {bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.halt_out, bus.hazard_stall});
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_decode();
    logic [31:0] instrs [13] = '{I_ADDU, I_BEQ, 32'h00031080, 32'h03E00008, 32'h14220003,
                                 32'hAC430008, 32'h3C010001, I_LW, 32'h0C000010,
                                 32'h34220005, 32'h00000000, 32'hFC000000, 32'h08000004};
    cvec_t exps [13];
    logic [31:0] w;
    exps[0]  = mk(0,0,0,6,1,0,1,0,0,0,0);  // ADDU
    exps[1]  = mk(0,0,1,7,0,2,0,1,0,0,0);  // BEQ
    exps[2]  = mk(2,0,0,0,1,0,1,0,0,0,0);  // SLL
    exps[3]  = mk(0,0,0,0,0,1,1,0,0,0,0);  // JR
    exps[4]  = mk(0,0,1,7,0,2,0,0,0,0,0);  // BNE
    exps[5]  = mk(1,0,1,6,0,0,0,0,0,1,0);  // SW
    exps[6]  = mk(1,2,0,0,1,0,0,0,0,0,0);  // LUI
    exps[7]  = mk(1,1,1,6,1,0,0,0,1,0,0);  // LW
    exps[8]  = mk(1,3,0,0,1,3,2,0,0,0,0);  // JAL
    exps[9]  = mk(1,0,0,3,1,0,0,0,0,0,0);  // ORI
    exps[10] = 18'h0;                      // all-zero word
    exps[11] = 18'h0;                      // opcode 3F, funct not 3F
    exps[12] = mk(1,0,0,0,0,3,0,0,0,0,0);  // J
    for (int i = 0; i < 13; i++) begin
      w = instrs[i];
      drive(w, 1'b1, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (got(0) !== exps[i]) begin
        n_errors++; $display("FAIL decode[%0d] ctrl got=%h exp=%h", i, got(0), exps[i]);
      end
      n_checks++;
      if ({bus.ex_rs, bus.ex_rt, bus.ex_rd} !== {w[25:21], w[20:16], w[15:11]}) begin
        n_errors++;
        $display("FAIL decode[%0d] regs got=%h exp=%h", i, {bus.ex_rs, bus.ex_rt, bus.ex_rd},
                 {w[25:21], w[20:16], w[15:11]});
      end
    end
    drive(I_ADDU, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd} !== 33'h0) begin
      n_errors++; $display("FAIL invalid_bubble got=%h exp=0", {got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd});
    end
  endtask

  task automatic test_hazard();
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADDU3, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.hazard_stall !== 1'b1) begin
      n_errors++; $display("FAIL hazard_rs got=%b exp=1", bus.hazard_stall);
    end
    tick();
    n_checks++;
    if ({got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd} !== 33'h0) begin
      n_errors++; $display("FAIL hazard_bubble got=%h exp=0", {got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd});
    end
    n_checks++;
    if (bus.hazard_stall !== 1'b0) begin
      n_errors++; $display("FAIL hazard_clear got=%b exp=0", bus.hazard_stall);
    end
    tick();
    n_checks++;
    if ({got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd} !== {mk(0,0,0,6,1,0,1,0,0,0,0), 5'd3, 5'd1, 5'd2}) begin
      n_errors++; $display("FAIL hazard_retry got=%h", {got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd});
    end
    // rt-as-source (BEQ) hazards; rt-as-destination (ADDIU) does not
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_BEQ, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.hazard_stall !== 1'b1) begin
      n_errors++; $display("FAIL hazard_rt got=%b exp=1", bus.hazard_stall);
    end
    drive(I_ADDIU, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.hazard_stall !== 1'b0) begin
      n_errors++; $display("FAIL hazard_rt_dest got=%b exp=0", bus.hazard_stall);
    end
    drive(I_ADDU3, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.hazard_stall !== 1'b0) begin
      n_errors++; $display("FAIL hazard_invalid got=%b exp=0", bus.hazard_stall);
    end
    // not gated by ex_stall; stalled edge holds the load
    drive(I_ADDU3, 1'b1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.hazard_stall !== 1'b1) begin
      n_errors++; $display("FAIL hazard_under_stall got=%b exp=1", bus.hazard_stall);
    end
    tick();
    n_checks++;
    if (got(0) !== mk(1,1,1,6,1,0,0,0,1,0,0)) begin
      n_errors++; $display("FAIL hazard_stall_hold got=%h", got(0));
    end
    // load to $0 never hazards
    drive(I_LW0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADDU00, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.hazard_stall !== 1'b0) begin
      n_errors++; $display("FAIL hazard_r0 got=%b exp=0", bus.hazard_stall);
    end
    tick();
    n_checks++;
    if (got(0) !== mk(0,0,0,6,1,0,1,0,0,0,0)) begin
      n_errors++; $display("FAIL hazard_r0_load got=%h", got(0));
    end
  endtask

  task automatic test_flush_stall();
    drive(I_ADDU, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_LW, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd} !== {mk(0,0,0,6,1,0,1,0,0,0,0), 5'd1, 5'd2, 5'd3}) begin
        n_errors++; $display("FAIL flush_stall_hold[%0d] got=%h", k, {got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd});
      end
    end
    drive(I_LW, 1'b1, 1'b0, 1'b1);
    tick();
    n_checks++;
    if ({got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd} !== 33'h0) begin
      n_errors++; $display("FAIL flush_bubble got=%h exp=0", {got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd});
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hazard_disabled();
    do_reset();
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    tick();
    drive(I_ADDU3, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({bus.hazard_stall, nh.hazard_stall} !== 2'b10) begin
      n_errors++; $display("FAIL hzd_en_stall got=%b exp=10", {bus.hazard_stall, nh.hazard_stall});
    end
    tick();
    n_checks++;
    if ({got(1), nh.ex_rs} !== {mk(0,0,0,6,1,0,1,0,0,0,0), 5'd3}) begin
      n_errors++; $display("FAIL hzd_off_load got=%h", {got(1), nh.ex_rs});
    end
    n_checks++;
    if (got(0) !== 18'h0) begin
      n_errors++; $display("FAIL hzd_on_bubble got=%h exp=0", got(0));
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_halt();
    drive(I_HALT, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({got(0), bus.halt_out} !== {18'h1, 1'b0}) begin
      n_errors++; $display("FAIL halt_load got=%h", {got(0), bus.halt_out});
    end
    // edge 2 stalled, edge 3 flushed: halt_out rises on edge 5
    for (int k = 1; k <= 8; k++) begin
      drive(I_ADDU, 1'b1, (k == 2), (k == 3));
      tick();
      n_checks++;
      if (bus.halt_out !== (k >= 5)) begin
        n_errors++; $display("FAIL halt_edge[%0d] got=%b exp=%b", k, bus.halt_out, (k >= 5));
      end
    end
    n_checks++;
    if (got(0) !== 18'h0) begin
      n_errors++; $display("FAIL halt_bubbles got=%h exp=0", got(0));
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge CLK);
    nRST = 1'b1;
    drive(I_ADDU, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if ({bus.ex_regwrite, bus.halt_out} !== 2'b01) begin
      n_errors++; $display("FAIL rst_pre got=%b exp=01", {bus.ex_regwrite, bus.halt_out});
    end
    #2 nRST = 1'b0;
    #1;
    n_checks++;
    if ({got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.halt_out} !== 34'h0) begin
      n_errors++; $display("FAIL rst_async got=%h exp=0", {got(0), bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.halt_out});
    end
    @(negedge CLK);
    nRST = 1'b1;
    drive(I_HALT, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick();  // drain counter now 2
    #2 nRST = 1'b0;
    #1;
    n_checks++;
    if ({bus.ex_halt, bus.halt_out} !== 2'b00) begin
      n_errors++; $display("FAIL rst_drain got=%b exp=00", {bus.ex_halt, bus.halt_out});
    end
    @(negedge CLK);
    nRST = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (bus.halt_out !== 1'b0) begin
      n_errors++; $display("FAIL rst_pending_cleared got=%b exp=0", bus.halt_out);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_hazard();
    test_flush_stall();
    test_hazard_disabled();
    test_halt();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
